// File: rtl/morph_frame_ctrl_if.sv
// Purpose: bundles the config, video timing and status signals of morph_frame_ctrl.
// Latency: none, this is wiring only.
// Backpressure: none; the video source is free-running.
// Ports: master drives cfg_wr/cfg_mode/in_de/in_hsync/in_vsync and observes status;
//        slave (the controller) sees the opposite directions.
interface morph_frame_ctrl_if #(
  parameter int COL = 1024,
  parameter int ROW = 768
);
  logic                    cfg_wr;
  logic [1:0]              cfg_mode;
  logic                    in_de;
  logic                    in_hsync;
  logic                    in_vsync;
  logic [1:0]              op_sel;
  logic [$clog2(COL)-1:0]  col_cnt;
  logic [$clog2(ROW)-1:0]  row_cnt;
  logic                    border;
  logic                    cfg_pending;
  logic                    frame_done;
  logic                    frame_err;
  logic [1:0]              state;

  modport master (
    output cfg_wr, cfg_mode, in_de, in_hsync, in_vsync,
    input  op_sel, col_cnt, row_cnt, border, cfg_pending,
           frame_done, frame_err, state
  );

  modport slave (
    input  cfg_wr, cfg_mode, in_de, in_hsync, in_vsync,
    output op_sel, col_cnt, row_cnt, border, cfg_pending,
           frame_done, frame_err, state
  );
endinterface

// File: rtl/morph_frame_ctrl.sv
// Purpose: frame-level controller for a 3x3 morphology filter: pixel counters, border flag,
//          frame-synchronous mode switching (bypass/erode/dilate/alternate) and frame status.
// Latency: counters show the current in_de pixel; border, op_sel, frame_err are registered (1 cycle).
// Backpressure: none; the video source cannot be stalled, in_de outside a frame is dropped.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries cfg_wr/cfg_mode,
//        in_de/in_hsync/in_vsync in, and op_sel, col_cnt, row_cnt, border, cfg_pending,
//        frame_done, frame_err, state out.
module morph_frame_ctrl #(
  parameter int COL = 1024,
  parameter int ROW = 768
) (
  input  logic                  clk,
  input  logic                  rst,
  morph_frame_ctrl_if.slave     bus
);

  localparam int CW = $clog2(COL);
  localparam int RW = $clog2(ROW);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic            vs_q;
  logic            vs_edge;
  logic [1:0]      shadow_mode;
  logic [1:0]      active_mode;
  logic [1:0]      new_mode;
  logic [1:0]      op_sel_q;
  logic            parity;
  logic            cfg_pending_q;
  logic            border_q;
  logic            frame_err_q;
  logic            frame_done_c;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic            col_last;
  logic            row_last;
  logic            pix;
  logic            last_pix;

  // Frame start is a rising edge of in_vsync against last cycle's sample.
  assign vs_edge  = bus.in_vsync & ~vs_q;

  assign col_last = (col_q == CW'(COL - 1));
  assign row_last = (row_q == RW'(ROW - 1));

  // A pixel counts only inside a frame; a vsync edge in the same cycle restarts
  // the frame, so that pixel is dropped.
  assign pix      = (state_q == ACTIVE) && bus.in_de && !vs_edge;
  assign last_pix = pix && col_last && row_last;

  // A config write coinciding with the vsync edge takes effect on that edge.
  assign new_mode = bus.cfg_wr ? bus.cfg_mode : shadow_mode;

  // vsync history keeps tracking through reset so a vsync held high across
  // reset release is not mistaken for a new frame.
  always_ff @(posedge clk) begin
    vs_q <= bus.in_vsync;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = WAIT_VS;
      WAIT_VS: if (vs_edge) state_d = ACTIVE;
      ACTIVE:  if (last_pix) state_d = DONE;
      DONE:    state_d = WAIT_VS;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    frame_done_c = 1'b0;
    if (state_q == DONE) begin
      frame_done_c = 1'b1;
    end
  end

  // Pixel counters. They hold the index of the pixel presented this cycle and
  // advance after it; the last pixel wraps both so the next frame starts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (vs_edge) begin
      col_q <= '0;
      row_q <= '0;
    end else if (pix) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_last ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // Mode shadowing: writes land in the shadow and are only promoted on a vsync
  // edge, so the operation never changes inside a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_mode   <= 2'b00;
      active_mode   <= 2'b00;
      cfg_pending_q <= 1'b0;
      parity        <= 1'b0;
    end else begin
      if (bus.cfg_wr) begin
        shadow_mode <= bus.cfg_mode;
      end

      if (vs_edge) begin
        active_mode   <= new_mode;
        cfg_pending_q <= 1'b0;
      end else if (bus.cfg_wr) begin
        cfg_pending_q <= 1'b1;
      end

      // Entering alternate mode always starts on an erode frame.
      if (vs_edge && (new_mode == 2'b11) && (active_mode != 2'b11)) begin
        parity <= 1'b0;
      end else if (state_q == DONE) begin
        parity <= ~parity;
      end
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_sel_q    <= 2'b00;
      border_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      case (active_mode)
        2'b00:   op_sel_q <= 2'b00;
        2'b01:   op_sel_q <= 2'b01;
        2'b10:   op_sel_q <= 2'b10;
        default: op_sel_q <= parity ? 2'b10 : 2'b01;
      endcase
      border_q    <= pix && ((col_q == '0) || col_last || (row_q == '0) || row_last);
      // A new vsync edge before the last pixel means the frame was truncated.
      frame_err_q <= (state_q == ACTIVE) && vs_edge;
    end
  end

  assign bus.op_sel      = op_sel_q;
  assign bus.col_cnt     = col_q;
  assign bus.row_cnt     = row_q;
  assign bus.border      = border_q;
  assign bus.cfg_pending = cfg_pending_q;
  assign bus.frame_done  = frame_done_c;
  assign bus.frame_err   = frame_err_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_morph_frame_ctrl.sv
// Purpose: directed self-checking bench for morph_frame_ctrl with a 4x3 frame.
// Latency: inputs change 1 time unit after each rising edge; outputs are sampled there too.
// Backpressure: none; every scenario runs a fixed number of cycles.
module tb_morph_frame_ctrl;
  localparam int COL = 4;
  localparam int ROW = 3;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  // Border flag per pixel index 0..11 (bit i): only (1,1) and (2,1) are interior.
  logic [11:0] border_map = 12'b1111_1001_1111;

  always #5 clk = ~clk;

  morph_frame_ctrl_if #(.COL(COL), .ROW(ROW)) bus();

  morph_frame_ctrl #(.COL(COL), .ROW(ROW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pixels(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_de = 1'b1;
      bus.in_hsync = (i % COL == 0);
      step();
    end
    bus.in_de = 1'b0;
    bus.in_hsync = 1'b0;
  endtask

  task automatic vsync_pulse();
    bus.in_vsync = 1'b1;
    step();
    bus.in_vsync = 1'b0;
    step();
  endtask

  // Full 12-pixel frame from a freshly zeroed ACTIVE state, checked pixel by pixel.
  task automatic run_frame_checked(input string tag);
    int done_cnt;
    done_cnt = 0;
    for (int i = 0; i < COL * ROW; i++) begin
      bus.in_de = 1'b1;
      total++; if (bus.col_cnt !== 2'(i % COL)) begin bad++; $display("FAIL %s_col[%0d] got=%0d exp=%0d", tag, i, bus.col_cnt, i % COL); end
      total++; if (bus.row_cnt !== 2'(i / COL)) begin bad++; $display("FAIL %s_row[%0d] got=%0d exp=%0d", tag, i, bus.row_cnt, i / COL); end
      step();
      total++; if (bus.border !== border_map[i]) begin bad++; $display("FAIL %s_border[%0d] got=%b exp=%b", tag, i, bus.border, border_map[i]); end
      if (bus.frame_done === 1'b1) done_cnt++;
    end
    bus.in_de = 1'b0;
    total++; if (bus.state !== 2'd3) begin bad++; $display("FAIL %s_state_done got=%0d exp=3", tag, bus.state); end
    step();
    total++; if (done_cnt != 1) begin bad++; $display("FAIL %s_done_count got=%0d exp=1", tag, done_cnt); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL %s_done_clear got=%b exp=0", tag, bus.frame_done); end
    total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL %s_state_wait got=%0d exp=1", tag, bus.state); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cfg_wr = 1'b0; bus.cfg_mode = 2'b00;
    bus.in_de = 1'b0; bus.in_hsync = 1'b0; bus.in_vsync = 1'b0;
    repeat (3) step();
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", bus.state); end
    total++; if (bus.op_sel !== 2'b00) begin bad++; $display("FAIL rst_op_sel got=%0d exp=0", bus.op_sel); end
    total++; if (bus.col_cnt !== 2'd0 || bus.row_cnt !== 2'd0) begin bad++; $display("FAIL rst_cnt got=%0d,%0d exp=0,0", bus.col_cnt, bus.row_cnt); end
    total++; if ({bus.border, bus.cfg_pending, bus.frame_done, bus.frame_err} !== 4'b0) begin bad++; $display("FAIL rst_flags got=%b exp=0000", {bus.border, bus.cfg_pending, bus.frame_done, bus.frame_err}); end
    rst = 1'b0;
    step();
    total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL rst_release_state got=%0d exp=1", bus.state); end
    // in_de before any vsync edge must not move the counters.
    bus.in_de = 1'b1;
    step(); step();
    bus.in_de = 1'b0;
    total++; if (bus.col_cnt !== 2'd0 || bus.border !== 1'b0) begin bad++; $display("FAIL wait_de_ignored got col=%0d border=%b exp col=0 border=0", bus.col_cnt, bus.border); end
  endtask

  task automatic test_full_frame();
    bus.in_vsync = 1'b1;
    step();
    total++; if (bus.state !== 2'd2) begin bad++; $display("FAIL full_enter_active got=%0d exp=2", bus.state); end
    bus.in_vsync = 1'b0;
    step();
    run_frame_checked("full");
  endtask

  task automatic test_cfg_mid_frame();
    vsync_pulse();
    pixels(3);
    bus.cfg_wr = 1'b1; bus.cfg_mode = 2'b01;
    step();
    bus.cfg_wr = 1'b0;
    total++; if (bus.cfg_pending !== 1'b1) begin bad++; $display("FAIL cfg_pending_set got=%b exp=1", bus.cfg_pending); end
    total++; if (bus.op_sel !== 2'b00) begin bad++; $display("FAIL cfg_op_hold got=%0d exp=0", bus.op_sel); end
    pixels(9);
    step();
    total++; if (bus.op_sel !== 2'b00 || bus.cfg_pending !== 1'b1) begin bad++; $display("FAIL cfg_between_frames got op=%0d pend=%b exp op=0 pend=1", bus.op_sel, bus.cfg_pending); end
    bus.in_vsync = 1'b1;
    step();
    bus.in_vsync = 1'b0;
    total++; if (bus.cfg_pending !== 1'b0) begin bad++; $display("FAIL cfg_pending_clear got=%b exp=0", bus.cfg_pending); end
    step();
    total++; if (bus.op_sel !== 2'b01) begin bad++; $display("FAIL cfg_op_applied got=%0d exp=1", bus.op_sel); end
    pixels(COL * ROW);
    step();
  endtask

  task automatic test_truncate();
    vsync_pulse();
    pixels(7);
    bus.in_vsync = 1'b1;
    step();
    bus.in_vsync = 1'b0;
    total++; if (bus.frame_err !== 1'b1) begin bad++; $display("FAIL trunc_err got=%b exp=1", bus.frame_err); end
    total++; if (bus.col_cnt !== 2'd0 || bus.row_cnt !== 2'd0) begin bad++; $display("FAIL trunc_cnt got=%0d,%0d exp=0,0", bus.col_cnt, bus.row_cnt); end
    total++; if (bus.state !== 2'd2 || bus.frame_done !== 1'b0) begin bad++; $display("FAIL trunc_state got=%0d done=%b exp=2 done=0", bus.state, bus.frame_done); end
    step();
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL trunc_err_pulse got=%b exp=0", bus.frame_err); end
    run_frame_checked("after_trunc");
  endtask

  task automatic test_alternate();
    logic [1:0] exp_op;
    bus.cfg_wr = 1'b1; bus.cfg_mode = 2'b11;
    step();
    bus.cfg_wr = 1'b0;
    for (int f = 0; f < 3; f++) begin
      vsync_pulse();
      exp_op = (f % 2 == 0) ? 2'b01 : 2'b10;
      total++; if (bus.op_sel !== exp_op) begin bad++; $display("FAIL alt_op[%0d] got=%0d exp=%0d", f, bus.op_sel, exp_op); end
      pixels(COL * ROW);
      step();
    end
  endtask

  task automatic test_reset_mid();
    vsync_pulse();
    pixels(5);
    bus.cfg_wr = 1'b1; bus.cfg_mode = 2'b10;
    step();
    bus.cfg_wr = 1'b0;
    bus.in_de = 1'b1;
    rst = 1'b1;
    step();
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL rmid_state got=%0d exp=0", bus.state); end
    total++; if (bus.col_cnt !== 2'd0 || bus.row_cnt !== 2'd0) begin bad++; $display("FAIL rmid_cnt got=%0d,%0d exp=0,0", bus.col_cnt, bus.row_cnt); end
    total++; if (bus.op_sel !== 2'b00) begin bad++; $display("FAIL rmid_op got=%0d exp=0", bus.op_sel); end
    total++; if ({bus.border, bus.cfg_pending, bus.frame_done, bus.frame_err} !== 4'b0) begin bad++; $display("FAIL rmid_flags got=%b exp=0000", {bus.border, bus.cfg_pending, bus.frame_done, bus.frame_err}); end
    rst = 1'b0;
    step();
    total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL rmid_wait got=%0d exp=1", bus.state); end
    step(); step();
    bus.in_de = 1'b0;
    total++; if (bus.col_cnt !== 2'd0 || bus.state !== 2'd1 || bus.frame_done !== 1'b0) begin bad++; $display("FAIL rmid_de_ignored got col=%0d state=%0d done=%b exp 0,1,0", bus.col_cnt, bus.state, bus.frame_done); end
    vsync_pulse();
    total++; if (bus.op_sel !== 2'b00 || bus.state !== 2'd2) begin bad++; $display("FAIL rmid_new_frame got op=%0d state=%0d exp op=0 state=2", bus.op_sel, bus.state); end
    pixels(COL * ROW);
    step();
  endtask

  task automatic test_cfg_same_edge();
    bus.cfg_wr = 1'b1; bus.cfg_mode = 2'b10; bus.in_vsync = 1'b1;
    step();
    bus.cfg_wr = 1'b0; bus.in_vsync = 1'b0;
    total++; if (bus.state !== 2'd2 || bus.cfg_pending !== 1'b0) begin bad++; $display("FAIL same_edge_apply got state=%0d pend=%b exp state=2 pend=0", bus.state, bus.cfg_pending); end
    step();
    total++; if (bus.op_sel !== 2'b10 || bus.cfg_pending !== 1'b0) begin bad++; $display("FAIL same_edge_op got op=%0d pend=%b exp op=2 pend=0", bus.op_sel, bus.cfg_pending); end
    pixels(COL * ROW);
    step();
    total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL same_edge_end got=%0d exp=1", bus.state); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_cfg_mid_frame();
    test_truncate();
    test_alternate();
    test_reset_mid();
    test_cfg_same_edge();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/morph_frame_ctrl.md
MORPH_FRAME_CTRL -- requirements
Module: morph_frame_ctrl

Interface
REQ-001 SHALL have parameter COL, default 1024, active pixels per line.
REQ-002 SHALL have parameter ROW, default 768, active lines per frame.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cfg_wr  input  1  one-cycle config write strobe.
REQ-006 SHALL have port cfg_mode  input  2  mode value: 00 bypass, 01 erode, 10 dilate, 11 alternate.
REQ-007 SHALL have ports in_de, in_hsync, in_vsync  input  1 each  video timing from the source.
REQ-008 SHALL have port op_sel  output  2  operation applied to the morphology datapath: 00 bypass, 01 erode, 10 dilate.
REQ-009 SHALL have port col_cnt  output  $clog2(COL)  column index of the current in_de pixel.
REQ-010 SHALL have port row_cnt  output  $clog2(ROW)  row index of the current in_de pixel.
REQ-011 SHALL have port border  output  1  window-edge flag for the 3x3 window.
REQ-012 SHALL have port cfg_pending  output  1  a written mode is waiting to be applied.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse on frame completion.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse when a frame is truncated.
REQ-015 SHALL have port state  output  2  FSM state: 0 IDLE, 1 WAIT_VS, 2 ACTIVE, 3 DONE.

Function
REQ-016 SHALL detect the start of a frame as an in_vsync rising edge, comparing against a one-cycle registered copy of in_vsync.
REQ-017 SHALL load cfg_mode into a shadow register on cfg_wr and set cfg_pending the next cycle.
REQ-018 On cfg_wr in the same cycle as a vsync edge, SHALL apply the new value directly and leave cfg_pending 0.
REQ-019 SHALL copy the shadow register into the active mode only on a vsync rising edge, then clear cfg_pending; the mode SHALL never change mid-frame.
REQ-020 FSM transitions:
- IDLE->WAIT_VS on the first cycle after reset release.
- WAIT_VS->ACTIVE on a vsync edge.
- ACTIVE->DONE on the in_de cycle where col_cnt==COL-1 and row_cnt==ROW-1.
- DONE->WAIT_VS unconditionally after one cycle.
REQ-021 SHALL zero both counters on entry to ACTIVE.
REQ-022 In ACTIVE, each in_de cycle SHALL advance col_cnt; col_cnt SHALL wrap from COL-1 to 0 and increment row_cnt at the same time.
REQ-023 SHALL advance counters only in ACTIVE; in_de in WAIT_VS, DONE or IDLE SHALL be ignored.
REQ-024 A vsync edge while in ACTIVE SHALL:
- pulse frame_err for one cycle;
- zero both counters;
- apply the shadow mode;
- stay in ACTIVE;
- not pulse frame_done.
REQ-025 SHALL pulse frame_done for exactly the one cycle spent in DONE.
REQ-026 op_sel SHALL be registered from the active mode:
- 00 -> 00; 01 -> 01; 10 -> 10.
- 11 -> 01 on even frames and 10 on odd frames, where the frame parity toggles at each DONE.
REQ-027 The frame parity SHALL reset to even whenever mode 11 is newly applied from a different mode.
REQ-028 border SHALL be registered, 1 cycle after the in_de pixel, and high when col_cnt==0, col_cnt==COL-1, row_cnt==0 or row_cnt==ROW-1; border SHALL be 0 when in_de was 0.
REQ-029 col_cnt and row_cnt SHALL reflect the index of the pixel presented on in_de in that same cycle; the count for that pixel SHALL be registered the following cycle.
REQ-030 in_hsync SHALL be used for nothing except pass-through observation; line wrap SHALL depend on counting only.

Reset
REQ-031 While rst=1, SHALL force:
- state=IDLE;
- op_sel=00, shadow and active mode=00, parity=even;
- col_cnt=0, row_cnt=0;
- border=0, cfg_pending=0, frame_done=0, frame_err=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame, with no frame_done or frame_err pulse.

Verification (COL=4, ROW=3)
REQ-033 cfg_wr mode=01 mid-frame -> cfg_pending=1, op_sel unchanged until the next vsync edge, then op_sel=01 and cfg_pending=0.
REQ-034 Full frame of 12 de pixels -> counters step (0,0)..(3,2), border=0 only for the pixels at (1,1) and (2,1), and frame_done pulses once, 1 cycle after the 12th pixel.
REQ-035 vsync edge after 7 pixels -> frame_err=1 for one cycle, counters at 0, state stays ACTIVE, and the next 12 pixels complete normally.
REQ-036 Mode 11 over 3 full frames -> op_sel 01, 10, 01.
REQ-037 rst pulse during row 1 -> all outputs return to reset values, state reaches WAIT_VS, and in_de is ignored until the next vsync edge.
REQ-038 cfg_wr in the same cycle as a vsync edge -> the new mode is applied on that edge and cfg_pending stays 0.
